// File: rtl/text_console_writer_pkg.sv
// Shared constants, state encoding and byte classification for the tile text writer.
package text_pkg;

  localparam logic [6:0] ASCII_BLANK = 7'h00;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] PRINT_LO    = 8'h20;
  localparam logic [7:0] PRINT_HI    = 8'h7E;

  typedef enum logic [1:0] {
    IDLE,
    ROWCLR,
    CLEAR
  } state_t;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= PRINT_LO) && (c <= PRINT_HI);
  endfunction

endpackage

// File: rtl/text_console_writer_if.sv
// Byte stream into the text console writer: valid/ready handshake carrying ASCII bytes.
interface text_console_writer_if;
  logic [7:0] char_in;
  logic       char_valid;
  logic       char_ready;

  modport master (output char_in, output char_valid, input  char_ready);
  modport slave  (input  char_in, input  char_valid, output char_ready);
endinterface

// File: rtl/text_console_writer.sv
// Cursor-driven writer into the tile text RAM: decodes ASCII bytes, handles
// CR/LF/BS and wrap, and blanks a row or the whole screen one cell per cycle.
module text_console_writer
  import text_pkg::*;
#(
  parameter int unsigned COLS = 16,
  parameter int unsigned ROWS = 4,
  localparam int unsigned CW  = $clog2(COLS),
  localparam int unsigned RW  = $clog2(ROWS)
) (
  input  logic                 clk,
  input  logic                 reset,
  text_console_writer_if.slave char_if,
  input  logic                 clear,
  output logic                 wr_en,
  output logic [RW+CW-1:0]     wr_addr,
  output logic [6:0]           wr_data,
  output logic [RW-1:0]        cur_row,
  output logic [CW-1:0]        cur_col,
  output logic                 busy
);

  state_t            state, state_d;
  logic [RW+CW-1:0]  fill, fill_d;
  logic [RW-1:0]     row_d;
  logic [CW-1:0]     col_d;
  logic              wr_en_d;
  logic [RW+CW-1:0]  addr_d;
  logic [6:0]        data_d;
  logic              accept;
  logic [CW-1:0]     col_dec;

  assign char_if.char_ready = (state == IDLE) && !clear;
  assign busy               = (state != IDLE);
  assign accept             = char_if.char_valid && char_if.char_ready;
  assign col_dec            = cur_col - CW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      fill    <= '0;
      cur_row <= '0;
      cur_col <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      state   <= state_d;
      fill    <= fill_d;
      cur_row <= row_d;
      cur_col <= col_d;
      wr_en   <= wr_en_d;
      wr_addr <= addr_d;
      wr_data <= data_d;
    end
  end

  always_comb begin
    state_d = state;
    fill_d  = fill;
    row_d   = cur_row;
    col_d   = cur_col;
    wr_en_d = 1'b0;
    addr_d  = wr_addr;
    data_d  = wr_data;

    // clear wins over everything, including a restart of an in-progress fill
    if (clear) begin
      state_d = CLEAR;
      fill_d  = '0;
      row_d   = '0;
      col_d   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            if (is_printable(char_if.char_in)) begin
              wr_en_d = 1'b1;
              addr_d  = {cur_row, cur_col};
              data_d  = char_if.char_in[6:0];
              if (cur_col != CW'(COLS - 1)) begin
                col_d = cur_col + CW'(1);
              end else begin
                col_d   = '0;
                row_d   = cur_row + RW'(1);
                fill_d  = '0;
                state_d = ROWCLR;
              end
            end else if (char_if.char_in == ASCII_CR) begin
              col_d = '0;
            end else if (char_if.char_in == ASCII_LF) begin
              col_d   = '0;
              row_d   = cur_row + RW'(1);
              fill_d  = '0;
              state_d = ROWCLR;
            end else if (char_if.char_in == ASCII_BS) begin
              if (cur_col != '0) begin
                col_d   = col_dec;
                wr_en_d = 1'b1;
                addr_d  = {cur_row, col_dec};
                data_d  = ASCII_BLANK;
              end
            end
          end
        end
        ROWCLR: begin
          wr_en_d = 1'b1;
          addr_d  = {cur_row, fill[CW-1:0]};
          data_d  = ASCII_BLANK;
          fill_d  = fill + (RW+CW)'(1);
          if (fill[CW-1:0] == '1) state_d = IDLE;
        end
        CLEAR: begin
          wr_en_d = 1'b1;
          addr_d  = fill;
          data_d  = ASCII_BLANK;
          fill_d  = fill + (RW+CW)'(1);
          if (fill == '1) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule
